// File: rtl/powerup_pkg.sv
// ---------------------------------------------------------------------------
// powerup_pkg
// Shared types and constants for the power-up sprite engine:
//   - life_state_e : lifetime FSM states (IDLE, ACTIVE, BLINK)
//   - SPRITE_SIZE / SPRITE_LOG : sprite edge length in pixels and its log2
//   - PAL_0..PAL_3 : 12-bit RGB for each 2-bit color index
//   - palette_lookup() : index to RGB mapping
// ---------------------------------------------------------------------------
package powerup_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLINK  = 2'd2
  } life_state_e;

  localparam int SPRITE_SIZE = 16;
  localparam int SPRITE_LOG  = 4;

  // Index 0 is transparent; its RGB is black so a miss never tints the frame.
  localparam logic [11:0] PAL_0 = 12'h000;
  localparam logic [11:0] PAL_1 = 12'hFF0;
  localparam logic [11:0] PAL_2 = 12'hF80;
  localparam logic [11:0] PAL_3 = 12'hFFF;

  function automatic logic [11:0] palette_lookup(input logic [1:0] idx);
    logic [11:0] color;
    case (idx)
      2'd0:    color = PAL_0;
      2'd1:    color = PAL_1;
      2'd2:    color = PAL_2;
      2'd3:    color = PAL_3;
      default: color = PAL_0;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/powerup_life_fsm.sv
// ---------------------------------------------------------------------------
// powerup_life_fsm
// Lifetime tracker for the single on-screen power-up.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   frame_tick        : one pulse per frame, advances the lifetime counter
//   spawn             : (re)starts the lifetime from any state
//   collect           : player pickup, accepted only while on screen
//   visible           : sprite should be drawn this frame (blinks near the end)
//   active            : registered, state is not IDLE
//   expired           : registered one-cycle pulse, lifetime ran out
//   collected         : registered one-cycle pulse, collect accepted
// Event priority: spawn > collect > frame_tick.
// ---------------------------------------------------------------------------
module powerup_life_fsm
  import powerup_pkg::*;
#(
  parameter int LIFETIME     = 600,
  parameter int BLINK_FRAMES = 120,
  parameter int BLINK_HALF   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic spawn,
  input  logic collect,
  output logic visible,
  output logic active,
  output logic expired,
  output logic collected
);

  localparam int CNT_W     = $clog2(LIFETIME + 1);
  localparam int BLINK_BIT = $clog2(BLINK_HALF);

  life_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec_s;
  logic             active_q, active_d;
  logic             expired_q, expired_d;
  logic             collected_q, collected_d;

  assign cnt_dec_s = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    expired_d   = 1'b0;
    collected_d = 1'b0;
    if (spawn) begin
      // A spawn while already on screen is a respawn: full reload, no pulse.
      state_d = ACTIVE;
      cnt_d   = CNT_W'(LIFETIME);
    end else if (collect && (state_q != IDLE)) begin
      // Collect wins over frame_tick, so the counter keeps its value.
      state_d     = IDLE;
      collected_d = 1'b1;
    end else if (frame_tick && (state_q != IDLE)) begin
      cnt_d = cnt_dec_s;
      case (state_q)
        ACTIVE: begin
          if (cnt_dec_s == CNT_W'(BLINK_FRAMES)) begin
            state_d = BLINK;
          end else begin
            state_d = ACTIVE;
          end
        end
        BLINK: begin
          if (cnt_dec_s == {CNT_W{1'b0}}) begin
            state_d   = IDLE;
            expired_d = 1'b1;
          end else begin
            state_d = BLINK;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    active_d = (state_d != IDLE);
  end

  // Visibility decode; during BLINK one counter bit toggles every BLINK_HALF frames.
  always_comb begin
    visible = 1'b0;
    case (state_q)
      IDLE:    visible = 1'b0;
      ACTIVE:  visible = 1'b1;
      BLINK:   visible = ~cnt_q[BLINK_BIT];
      default: visible = 1'b0;
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      active_q    <= 1'b0;
      expired_q   <= 1'b0;
      collected_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      expired_q   <= expired_d;
      collected_q <= collected_d;
    end
  end

  assign active    = active_q;
  assign expired   = expired_q;
  assign collected = collected_q;

endmodule

// File: rtl/powerup_sprite_gen.sv
// ---------------------------------------------------------------------------
// powerup_sprite_gen
// Read-side sprite engine for the 16x16 power-up bitmap RAM.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   x, y                    : current pixel counters
//   frame_tick              : frame start pulse
//   spawn, spawn_x, spawn_y : start lifetime and latch top-left origin
//   collect                 : player pickup
//   addr_r                  : bitmap RAM read address (registered)
//   ram_dout                : RAM read data, one cycle after addr_r
//   rgb, hit                : sprite pixel colour / opaque-and-visible flag
//   active, expired, collected : lifetime status and pulses
// Pixel pipeline: T+1 address/region/visible, T+2 RAM data aligned,
// T+3 rgb/hit registered.
// ---------------------------------------------------------------------------
module powerup_sprite_gen
  import powerup_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 2,
  parameter int LIFETIME     = 600,
  parameter int BLINK_FRAMES = 120,
  parameter int BLINK_HALF   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_tick,
  input  logic                  spawn,
  input  logic [10:0]           spawn_x,
  input  logic [10:0]           spawn_y,
  input  logic                  collect,
  output logic [ADDR_WIDTH-1:0] addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [11:0]           rgb,
  output logic                  hit,
  output logic                  active,
  output logic                  expired,
  output logic                  collected
);

  logic                  visible_s;
  logic [10:0]           origin_x_q, origin_x_d;
  logic [10:0]           origin_y_q, origin_y_d;
  logic [11:0]           dx_s, dy_s;
  logic                  in_region_s;
  logic [ADDR_WIDTH-1:0] addr_r_q, addr_r_d;
  logic                  in_region_d1_q, visible_d1_q;
  logic                  in_region_d2_q, visible_d2_q;
  logic [11:0]           rgb_q, rgb_d;
  logic                  hit_q, hit_d;

  powerup_life_fsm #(
    .LIFETIME     (LIFETIME),
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_HALF   (BLINK_HALF)
  ) u_life (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .spawn      (spawn),
    .collect    (collect),
    .visible    (visible_s),
    .active     (active),
    .expired    (expired),
    .collected  (collected)
  );

  // Origin latch and region/address decode for the current pixel.
  always_comb begin
    origin_x_d = origin_x_q;
    origin_y_d = origin_y_q;
    if (spawn) begin
      origin_x_d = spawn_x;
      origin_y_d = spawn_y;
    end else begin
      origin_x_d = origin_x_q;
      origin_y_d = origin_y_q;
    end
    // 12-bit differences: bit 11 is the sign, so pixels left/above the
    // origin never alias back into the sprite (no wrap-around).
    dx_s = {1'b0, x} - {1'b0, origin_x_q};
    dy_s = {1'b0, y} - {1'b0, origin_y_q};
    // Upper bits all zero means non-negative and below SPRITE_SIZE.
    in_region_s = (dx_s[11:SPRITE_LOG] == {(12-SPRITE_LOG){1'b0}}) &&
                  (dy_s[11:SPRITE_LOG] == {(12-SPRITE_LOG){1'b0}});
    if (in_region_s) begin
      addr_r_d = {dy_s[SPRITE_LOG-1:0], dx_s[SPRITE_LOG-1:0]};
    end else begin
      addr_r_d = {ADDR_WIDTH{1'b0}};
    end
  end

  // Palette stage; runs on data aligned with the second pipeline stage.
  always_comb begin
    hit_d = in_region_d2_q && visible_d2_q && (ram_dout != {DATA_WIDTH{1'b0}});
    if (hit_d) begin
      rgb_d = palette_lookup(ram_dout);
    end else begin
      rgb_d = PAL_0;
    end
  end

  // Origin and pixel pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      origin_x_q     <= 11'd0;
      origin_y_q     <= 11'd0;
      addr_r_q       <= {ADDR_WIDTH{1'b0}};
      in_region_d1_q <= 1'b0;
      visible_d1_q   <= 1'b0;
      in_region_d2_q <= 1'b0;
      visible_d2_q   <= 1'b0;
      rgb_q          <= 12'h000;
      hit_q          <= 1'b0;
    end else begin
      origin_x_q     <= origin_x_d;
      origin_y_q     <= origin_y_d;
      addr_r_q       <= addr_r_d;
      in_region_d1_q <= in_region_s;
      visible_d1_q   <= visible_s;
      in_region_d2_q <= in_region_d1_q;
      visible_d2_q   <= visible_d1_q;
      rgb_q          <= rgb_d;
      hit_q          <= hit_d;
    end
  end

  assign addr_r = addr_r_q;
  assign rgb    = rgb_q;
  assign hit    = hit_q;

endmodule
